// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised single-clock FIFO with thresholds and sticky error flags
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_acc;
    logic                  pop_acc;

    // A push into a full FIFO is legal only when the head is leaving on the same edge.
    assign push_acc = wr_en & (~full | rd_en);
    assign pop_acc  = rd_en & ~empty;

    assign full         = (fill_count == DEPTH_CNT);
    assign empty        = (fill_count == '0);
    assign almost_full  = (fill_count >= AF_CNT);
    assign almost_empty = (fill_count <= AE_CNT);

    always_ff @(posedge clk) begin
        if (push_acc && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill_count <= fill_count + (ADDR_WIDTH+1)'(push_acc) - (ADDR_WIDTH+1)'(pop_acc);
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_acc;
            if (pop_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param against a queue model
module tb_sync_fifo_param;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AF_TH  = 12;
    localparam int AE_TH  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   fill_count;
    logic          overflow;
    logic          underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_hold = '0;

    sync_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF_TH), .AEMPTY_THRESH(AE_TH)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .fill_count(fill_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue; acceptance follows from its size.
    always @(posedge clk) begin
        int sz;
        logic push_ok, pop_ok;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
            exp_valid = 1'b0;
            exp_hold  = '0;
        end else begin
            sz      = model_q.size();
            push_ok = wr_en && (sz < DEPTH || rd_en);
            pop_ok  = rd_en && (sz > 0);
            if (wr_en && sz == DEPTH && !rd_en) m_ovf = 1'b1;
            if (rd_en && sz == 0) m_unf = 1'b1;
            if (pop_ok) begin
                exp_hold = model_q.pop_front();
                exp_q.push_back(exp_hold);
            end
            if (push_ok) model_q.push_back(wr_data);
            exp_valid = pop_ok;
        end
    end

    // Monitor: samples DUT outputs on the falling edge.
    initial begin
        logic [DW-1:0] e;
        int sz;
        @(posedge clk);
        forever begin
            @(negedge clk);
            sz = model_q.size();
            check("fill_count",   32'(fill_count),   32'(sz));
            check("full",         32'(full),         32'(sz == DEPTH));
            check("empty",        32'(empty),        32'(sz == 0));
            check("almost_full",  32'(almost_full),  32'(sz >= AF_TH));
            check("almost_empty", 32'(almost_empty), 32'(sz <= AE_TH));
            check("overflow",     32'(overflow),     32'(m_ovf));
            check("underflow",    32'(underflow),    32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
            check("rd_valid", 32'(rd_valid), 32'(sz != 0));
            if (rd_valid && sz != 0) check("rd_data_head", 32'(rd_data), 32'(model_q[0]));
            exp_q.delete();
`else
            check("rd_valid", 32'(rd_valid), 32'(exp_valid));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e));
                end
            end
            check("rd_data_hold", 32'(rd_data), 32'(exp_hold));
`endif
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        rst     = rs;
    endtask

    initial begin
        logic w, r;
        int sz;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);

        for (int i = 0; i < 16; i++) cyc(1, 0, DW'(i), 0);
        cyc(1, 0, 8'hAA, 0);
        cyc(1, 1, 8'h77, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(0, 1, 0, 0);
        cyc(1, 1, 8'h55, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);

        cyc(0, 0, 0, 1);
        repeat (3) cyc(1, 0, DW'($urandom), 0);
        for (int i = 0; i < 40; i++) begin
            sz = model_q.size();
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            if (sz <= 1 && r && !w) r = 1'b0;
            if (sz >= 15 && w && !r) w = 1'b0;
            cyc(w, r, DW'($urandom), 0);
        end

        for (int i = 0; i < 240; i++) begin
            int p;
            p = ((i / 40) % 2 == 0) ? 75 : 25;
            w = ($urandom_range(0, 99) < p);
            r = ($urandom_range(0, 99) >= p);
            if ($urandom_range(0, 9) == 0) r = 1'b1;
            cyc(w, r, DW'($urandom), 0);
        end

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, 0, DW'($urandom), 0);
        cyc(1, 1, 8'h3C, 1);
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
